// File: rtl/player_missile.sv
// player_missile: the player's single missile for the Galaxian playfield.
// A rising edge on fire launches the missile from the top-centre of the ship;
// it climbs Y_STEP pixels per frame and retires on an alien hit or at the top
// of the screen. While idle it is parked far off-screen so no alien overlaps it.
// Optional feature macro: MISSILE_COOLDOWN_EN (adds a COOLDOWN state and a
// 5-bit frame counter that blocks re-fire for COOLDOWN_FRAMES frames).
module player_missile #(
  parameter int MISSILE_W       = 3,
  parameter int MISSILE_H       = 6,
  parameter int Y_STEP          = 8,
  parameter int PARK_X          = 700,
  parameter int PARK_Y          = 1000,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [9:0] PlayerX,
  input  logic [9:0] PlayerY,
  input  logic [9:0] PlayerS,
  input  logic       hit,
  output logic [9:0] MissileX,
  output logic [9:0] MissileY,
  output logic [9:0] MissileS,
  output logic       active,
  output logic [7:0] shots
);

  localparam logic [9:0] PARK_X_V = 10'(PARK_X);
  localparam logic [9:0] PARK_Y_V = 10'(PARK_Y);
  localparam logic [9:0] HALF_W_V = 10'(MISSILE_W >> 1);
  localparam logic [9:0] H_V      = 10'(MISSILE_H);
  localparam logic [9:0] STEP_V   = 10'(Y_STEP);

  // The counter is 5 bits wide, so the cooldown length must fit in 1..32;
  // an out-of-range setting leaves this marker block in the elaborated design.
  if (COOLDOWN_FRAMES < 1 || COOLDOWN_FRAMES > 32) begin : g_cooldown_frames_out_of_range
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1
`ifdef MISSILE_COOLDOWN_EN
    ,
    COOLDOWN = 2'd2
`endif
  } state_t;

  state_t     state_reg, state_next;
  logic [9:0] x_reg, x_next;
  logic [9:0] y_reg, y_next;
  logic [7:0] shots_reg, shots_next;
  logic       fire_q_reg;
  logic       launch_req;
  logic [9:0] launch_x;
  logic [9:0] launch_y;
`ifdef MISSILE_COOLDOWN_EN
  localparam logic [4:0] CD_LOAD_V = 5'(COOLDOWN_FRAMES - 1);
  logic [4:0] cnt_reg, cnt_next;
`endif

  // Launch request is an edge on the fire button so a held button never repeats.
  assign launch_req = fire & ~fire_q_reg;

  // Launch point: ship top-centre, missile centred on it; the top is clamped at 0.
  assign launch_x = PlayerX + (PlayerS >> 1) - HALF_W_V;
  assign launch_y = (PlayerY < H_V) ? 10'd0 : (PlayerY - H_V);

  // State, coordinates, shot counter and fire history registered once per frame.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_reg  <= IDLE;
      x_reg      <= PARK_X_V;
      y_reg      <= PARK_Y_V;
      shots_reg  <= 8'd0;
      fire_q_reg <= 1'b0;
`ifdef MISSILE_COOLDOWN_EN
      cnt_reg    <= 5'd0;
`endif
    end else begin
      state_reg  <= state_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      shots_reg  <= shots_next;
      fire_q_reg <= fire;
`ifdef MISSILE_COOLDOWN_EN
      cnt_reg    <= cnt_next;
`endif
    end
  end

  // Next-state logic: launch from IDLE, climb or retire while FLYING, wait out cooldown.
  always_comb begin
    state_next = state_reg;
    x_next     = x_reg;
    y_next     = y_reg;
    shots_next = shots_reg;
`ifdef MISSILE_COOLDOWN_EN
    cnt_next   = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (launch_req) begin
          state_next = FLYING;
          x_next     = launch_x;
          y_next     = launch_y;
          shots_next = (shots_reg == 8'hFF) ? shots_reg : shots_reg + 8'd1;
        end
      end
      FLYING: begin
        // Retiring below Y_STEP keeps the 10-bit subtraction from wrapping;
        // a coincident hit retires the same single time.
        if (hit || (y_reg < STEP_V)) begin
          x_next     = PARK_X_V;
          y_next     = PARK_Y_V;
`ifdef MISSILE_COOLDOWN_EN
          state_next = COOLDOWN;
          cnt_next   = CD_LOAD_V;
`else
          state_next = IDLE;
`endif
        end else begin
          y_next = y_reg - STEP_V;
        end
      end
`ifdef MISSILE_COOLDOWN_EN
      COOLDOWN: begin
        if (cnt_reg == 5'd0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 5'd1;
        end
      end
`endif
      default: begin
        state_next = IDLE;
        x_next     = PARK_X_V;
        y_next     = PARK_Y_V;
      end
    endcase
  end

  assign MissileX = x_reg;
  assign MissileY = y_reg;
  assign MissileS = 10'(MISSILE_W);
  assign active   = (state_reg == FLYING);
  assign shots    = shots_reg;

endmodule
